// File: rtl/pong_sequencer.sv
// Game-level controller for the 8x8 pong field: ball, paddles, scores and game FSM.
// Define PONG_SPEEDUP_EN to shorten the tick period on every paddle bounce.
module pong_sequencer #(
   parameter logic [15:0] TICK_DIV   = 16'd50000,
   parameter logic [3:0]  MAX_SCORE  = 4'd9
`ifdef PONG_SPEEDUP_EN
   ,
   parameter logic [15:0] SPEED_STEP = 16'd2000,
   parameter logic [15:0] MIN_DIV    = 16'd10000
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       top_left,
   input  logic       top_right,
   input  logic       bot_left,
   input  logic       bot_right,
   output logic [2:0] ball_x,
   output logic [2:0] ball_y,
   output logic [2:0] paddle_top,
   output logic [2:0] paddle_bot,
   output logic [3:0] score_top,
   output logic [3:0] score_bot,
   output logic [1:0] game_state,
   output logic       point,
   output logic       endgame
);

   localparam int unsigned POS_W   = 3;
   localparam int unsigned SCORE_W = 4;
   localparam int unsigned CNT_W   = 16;

   localparam logic [POS_W-1:0] CENTER  = POS_W'(3);
   localparam logic [POS_W-1:0] POS_MAX = POS_W'(7);
   localparam logic [POS_W-1:0] PAD_MAX = POS_W'(6);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_RUN   = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [POS_W-1:0]     ball_x_q, ball_x_d;
   logic [POS_W-1:0]     ball_y_q, ball_y_d;
   logic                 dx_neg_q, dx_neg_d;
   logic                 dy_neg_q, dy_neg_d;
   logic [POS_W-1:0]     paddle_top_q, paddle_top_d;
   logic [POS_W-1:0]     paddle_bot_q, paddle_bot_d;
   logic [SCORE_W-1:0]   score_top_q, score_top_d;
   logic [SCORE_W-1:0]   score_bot_q, score_bot_d;
   logic                 point_q, point_d;
   logic                 endgame_q, endgame_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     period_c;

   logic                 step_c;
   logic                 next_dx_neg_c;
   logic                 top_hit_c;
   logic                 bot_hit_c;
   logic [SCORE_W-1:0]   score_top_inc_c;
   logic [SCORE_W-1:0]   score_bot_inc_c;

   // Saturating paddle move; opposing pulses in the same cycle cancel.
   function automatic logic [POS_W-1:0] paddle_next(input logic [POS_W-1:0] p,
                                                    input logic            l,
                                                    input logic            r);
      logic [POS_W-1:0] n;
      n = p;
      if (l && !r && (p != POS_W'(0)))
         n = p - POS_W'(1);
      else if (r && !l && (p < PAD_MAX))
         n = p + POS_W'(1);
      return n;
   endfunction

   function automatic logic covers(input logic [POS_W-1:0] x, input logic [POS_W-1:0] p);
      return (x == p) || (x == (p + POS_W'(1)));
   endfunction

`ifdef PONG_SPEEDUP_EN
   logic [CNT_W-1:0] period_q, period_d;

   function automatic logic [CNT_W-1:0] sped_up(input logic [CNT_W-1:0] p);
      return ((p - MIN_DIV) >= SPEED_STEP) ? (p - SPEED_STEP) : MIN_DIV;
   endfunction

   assign period_c = period_q;
`else
   assign period_c = TICK_DIV;
`endif

   assign step_c          = (cnt_q == (period_c - CNT_W'(1)));
   assign next_dx_neg_c   = (ball_x_q == POS_MAX) ? 1'b1 :
                            (ball_x_q == POS_W'(0)) ? 1'b0 : dx_neg_q;
   assign top_hit_c       = covers(ball_x_q, paddle_top_q);
   assign bot_hit_c       = covers(ball_x_q, paddle_bot_q);
   assign score_top_inc_c = (score_top_q < MAX_SCORE) ? (score_top_q + SCORE_W'(1)) : score_top_q;
   assign score_bot_inc_c = (score_bot_q < MAX_SCORE) ? (score_bot_q + SCORE_W'(1)) : score_bot_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ball_x_q     <= CENTER;
         ball_y_q     <= CENTER;
         dx_neg_q     <= 1'b0;
         dy_neg_q     <= 1'b0;
         paddle_top_q <= CENTER;
         paddle_bot_q <= CENTER;
         score_top_q  <= '0;
         score_bot_q  <= '0;
         point_q      <= 1'b0;
         endgame_q    <= 1'b0;
         cnt_q        <= '0;
`ifdef PONG_SPEEDUP_EN
         period_q     <= TICK_DIV;
`endif
      end else begin
         state_q      <= state_d;
         ball_x_q     <= ball_x_d;
         ball_y_q     <= ball_y_d;
         dx_neg_q     <= dx_neg_d;
         dy_neg_q     <= dy_neg_d;
         paddle_top_q <= paddle_top_d;
         paddle_bot_q <= paddle_bot_d;
         score_top_q  <= score_top_d;
         score_bot_q  <= score_bot_d;
         point_q      <= point_d;
         endgame_q    <= endgame_d;
         cnt_q        <= cnt_d;
`ifdef PONG_SPEEDUP_EN
         period_q     <= period_d;
`endif
      end
   end

   // Next-state and datapath; serve_entry centralises the ball/counter reload.
   always_comb begin
      logic serve_entry;
      logic serve_dy_neg;

      state_d      = state_q;
      ball_x_d     = ball_x_q;
      ball_y_d     = ball_y_q;
      dx_neg_d     = dx_neg_q;
      dy_neg_d     = dy_neg_q;
      score_top_d  = score_top_q;
      score_bot_d  = score_bot_q;
      point_d      = 1'b0;
      cnt_d        = step_c ? '0 : (cnt_q + CNT_W'(1));
      paddle_top_d = paddle_next(paddle_top_q, top_left, top_right);
      paddle_bot_d = paddle_next(paddle_bot_q, bot_left, bot_right);
      serve_entry  = 1'b0;
      serve_dy_neg = 1'b0;
`ifdef PONG_SPEEDUP_EN
      period_d     = period_q;
`endif

      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               state_d     = ST_SERVE;
               score_top_d = '0;
               score_bot_d = '0;
               serve_entry = 1'b1;
            end
         end
         ST_SERVE: begin
            if (step_c)
               state_d = ST_RUN;
         end
         ST_RUN: begin
            if (ball_y_q == POS_W'(0)) begin
               point_d      = 1'b1;
               score_bot_d  = score_bot_inc_c;
               state_d      = (score_bot_inc_c == MAX_SCORE) ? ST_OVER : ST_SERVE;
               serve_entry  = (score_bot_inc_c != MAX_SCORE);
               serve_dy_neg = 1'b1;
            end else if (ball_y_q == POS_MAX) begin
               point_d      = 1'b1;
               score_top_d  = score_top_inc_c;
               state_d      = (score_top_inc_c == MAX_SCORE) ? ST_OVER : ST_SERVE;
               serve_entry  = (score_top_inc_c != MAX_SCORE);
               serve_dy_neg = 1'b0;
            end else if (step_c) begin
               dx_neg_d = next_dx_neg_c;
               ball_x_d = next_dx_neg_c ? (ball_x_q - POS_W'(1)) : (ball_x_q + POS_W'(1));
               if ((ball_y_q == POS_W'(1)) && dy_neg_q) begin
                  if (top_hit_c) begin
                     dy_neg_d = 1'b0;
                     ball_y_d = POS_W'(2);
`ifdef PONG_SPEEDUP_EN
                     period_d = sped_up(period_q);
`endif
                  end else begin
                     ball_y_d = POS_W'(0);
                  end
               end else if ((ball_y_q == PAD_MAX) && !dy_neg_q) begin
                  if (bot_hit_c) begin
                     dy_neg_d = 1'b1;
                     ball_y_d = POS_W'(5);
`ifdef PONG_SPEEDUP_EN
                     period_d = sped_up(period_q);
`endif
                  end else begin
                     ball_y_d = POS_MAX;
                  end
               end else begin
                  ball_y_d = dy_neg_q ? (ball_y_q - POS_W'(1)) : (ball_y_q + POS_W'(1));
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (serve_entry) begin
         ball_x_d = CENTER;
         ball_y_d = CENTER;
         dy_neg_d = serve_dy_neg;
         cnt_d    = '0;
`ifdef PONG_SPEEDUP_EN
         period_d = TICK_DIV;
`endif
      end

      endgame_d = (state_d == ST_OVER);
   end

   assign ball_x     = ball_x_q;
   assign ball_y     = ball_y_q;
   assign paddle_top = paddle_top_q;
   assign paddle_bot = paddle_bot_q;
   assign score_top  = score_top_q;
   assign score_bot  = score_bot_q;
   assign game_state = state_q;
   assign point      = point_q;
   assign endgame    = endgame_q;

endmodule
